// File: rtl/mer_tc0_pkt_fifo_pkg.sv
// Packet layout shared by the Mer -> TC0 queue: field widths, bit positions and pack/unpack helpers.
package mer_tc0_pkt_fifo_pkg;
   localparam int LR_W   = 1;
   localparam int NODE_W = 16;
   localparam int GEN_W  = 12;
   localparam int OPR_W  = 32;
   localparam int UNI_W  = 1;
   localparam int WEN_W  = 2;
   localparam int PKT_W  = LR_W + NODE_W + GEN_W + OPR_W + UNI_W + WEN_W;

   // Field order, MSB first: lr, node, gen, opr, uni_opr, mem_wen
   localparam int WEN_LSB  = 0;
   localparam int UNI_LSB  = WEN_LSB + WEN_W;
   localparam int OPR_LSB  = UNI_LSB + UNI_W;
   localparam int GEN_LSB  = OPR_LSB + OPR_W;
   localparam int NODE_LSB = GEN_LSB + GEN_W;
   localparam int LR_LSB   = NODE_LSB + NODE_W;

   typedef struct packed {
      logic [LR_W-1:0]   lr;
      logic [NODE_W-1:0] node;
      logic [GEN_W-1:0]  gen;
      logic [OPR_W-1:0]  opr;
      logic [UNI_W-1:0]  uni_opr;
      logic [WEN_W-1:0]  mem_wen;
   } pkt_t;

   function automatic logic [PKT_W-1:0] pkt_pack(input pkt_t p);
      logic [PKT_W-1:0] v;
      v = '0;
      v[LR_LSB   +: LR_W]   = p.lr;
      v[NODE_LSB +: NODE_W] = p.node;
      v[GEN_LSB  +: GEN_W]  = p.gen;
      v[OPR_LSB  +: OPR_W]  = p.opr;
      v[UNI_LSB  +: UNI_W]  = p.uni_opr;
      v[WEN_LSB  +: WEN_W]  = p.mem_wen;
      return v;
   endfunction

   function automatic pkt_t pkt_unpack(input logic [PKT_W-1:0] v);
      pkt_t p;
      p.lr      = v[LR_LSB   +: LR_W];
      p.node    = v[NODE_LSB +: NODE_W];
      p.gen     = v[GEN_LSB  +: GEN_W];
      p.opr     = v[OPR_LSB  +: OPR_W];
      p.uni_opr = v[UNI_LSB  +: UNI_W];
      p.mem_wen = v[WEN_LSB  +: WEN_W];
      return p;
   endfunction
endpackage

// File: rtl/mer_tc0_pkt_fifo_if.sv
// Mer-side push bus, TC0-side valid/ready bus and arbiter status for the packet queue.
interface mer_tc0_pkt_fifo_if #(parameter int DEPTH = 8);
   localparam int CW = $clog2(DEPTH) + 1;

   logic        vld_mer_i_fifo;
   logic        lr_mer_i_fifo;
   logic [15:0] node_mer_i_fifo;
   logic [11:0] gen_mer_i_fifo;
   logic [31:0] opr_mer_i_fifo;
   logic        uni_opr_mer_i_fifo;
   logic [1:0]  mem_wen_mer_i_fifo;
   logic        rdy_tc0_i_fifo;

   logic          vld_o_fifo;
   logic          lr_o_fifo;
   logic [15:0]   node_o_fifo;
   logic [11:0]   gen_o_fifo;
   logic [31:0]   opr_o_fifo;
   logic          uni_opr_o_fifo;
   logic [1:0]    mem_wen_o_fifo;
   logic          aeb_o_fifo;
   logic          afb_o_fifo;
   logic [CW-1:0] cnt_o_fifo;
   logic          ovf_o_fifo;

   modport master (
      output vld_mer_i_fifo, lr_mer_i_fifo, node_mer_i_fifo, gen_mer_i_fifo, opr_mer_i_fifo,
             uni_opr_mer_i_fifo, mem_wen_mer_i_fifo, rdy_tc0_i_fifo,
      input  vld_o_fifo, lr_o_fifo, node_o_fifo, gen_o_fifo, opr_o_fifo, uni_opr_o_fifo,
             mem_wen_o_fifo, aeb_o_fifo, afb_o_fifo, cnt_o_fifo, ovf_o_fifo
   );

   modport slave (
      input  vld_mer_i_fifo, lr_mer_i_fifo, node_mer_i_fifo, gen_mer_i_fifo, opr_mer_i_fifo,
             uni_opr_mer_i_fifo, mem_wen_mer_i_fifo, rdy_tc0_i_fifo,
      output vld_o_fifo, lr_o_fifo, node_o_fifo, gen_o_fifo, opr_o_fifo, uni_opr_o_fifo,
             mem_wen_o_fifo, aeb_o_fifo, afb_o_fifo, cnt_o_fifo, ovf_o_fifo
   );
endinterface

// File: rtl/mer_tc0_pkt_fifo_ram.sv
// Packet storage: synchronous write, asynchronous read so it can live in distributed RAM.
module mer_tc0_pkt_fifo_ram
   import mer_tc0_pkt_fifo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [PKT_W-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [PKT_W-1:0]         rdata_o
);
   logic [PKT_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mer_tc0_pkt_fifo.sv
// Elastic Mer -> TC0 packet queue with a registered show-ahead head and almost-empty/full status.
module mer_tc0_pkt_fifo
   import mer_tc0_pkt_fifo_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int AE_LEVEL = 1,
   parameter int AF_LEVEL = 6
) (
   input logic              clk,
   input logic              rst,
   mer_tc0_pkt_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d, vld_q;
   pkt_t             head_q, head_d, in_pkt;
   logic [PKT_W-1:0] ram_rdata;
   logic             full, push, pop;

   always_comb begin
      in_pkt.lr      = bus.lr_mer_i_fifo;
      in_pkt.node    = bus.node_mer_i_fifo;
      in_pkt.gen     = bus.gen_mer_i_fifo;
      in_pkt.opr     = bus.opr_mer_i_fifo;
      in_pkt.uni_opr = bus.uni_opr_mer_i_fifo;
      in_pkt.mem_wen = bus.mem_wen_mer_i_fifo;

      full = (cnt_q == CW'(DEPTH));
      pop  = vld_q & bus.rdy_tc0_i_fifo;
      // A pop frees the slot this cycle, so a full queue can still take the push.
      push = bus.vld_mer_i_fifo & (~full | pop);

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q | (bus.vld_mer_i_fifo & full & ~pop);

      // Next head is being written this same edge when it sits at wr_ptr: bypass the RAM.
      head_d = head_q;
      if (cnt_d != '0) begin
         if (push && (rd_ptr_d == wr_ptr_q)) head_d = in_pkt;
         else                                head_d = pkt_unpack(ram_rdata);
      end
   end

   mer_tc0_pkt_fifo_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (pkt_pack(in_pkt)),
      .raddr_i (rd_ptr_d),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         vld_q    <= (cnt_d != '0);
         head_q   <= head_d;
      end
   end

   assign bus.vld_o_fifo     = vld_q;
   assign bus.lr_o_fifo      = head_q.lr;
   assign bus.node_o_fifo    = head_q.node;
   assign bus.gen_o_fifo     = head_q.gen;
   assign bus.opr_o_fifo     = head_q.opr;
   assign bus.uni_opr_o_fifo = head_q.uni_opr;
   assign bus.mem_wen_o_fifo = head_q.mem_wen;
   assign bus.cnt_o_fifo     = cnt_q;
   assign bus.aeb_o_fifo     = (cnt_q <= CW'(AE_LEVEL));
   assign bus.afb_o_fifo     = (cnt_q >= CW'(AF_LEVEL));
   assign bus.ovf_o_fifo     = ovf_q;
endmodule
